// File: rtl/mem_pkg.sv
// Shared widths and types for the data-memory responder.
// Contents: line/byte-enable types, loader FSM states, loader geometry.
package mem_pkg;

    localparam int unsigned ADDR_W         = 14;
    localparam int unsigned DATA_W         = 256;
    localparam int unsigned BE_W           = DATA_W / 8;
    localparam int unsigned LD_W           = 32;
    localparam int unsigned WORDS_PER_LINE = DATA_W / LD_W;
    localparam int unsigned BEAT_W         = $clog2(WORDS_PER_LINE);

    typedef logic [DATA_W-1:0] line_t;
    typedef logic [BE_W-1:0]   be_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_FILL,
        LD_COMMIT,
        LD_DONE
    } ld_state_t;

endpackage

// File: rtl/data_mem_ram_core.sv
// Single-port line RAM with byte-enabled writes and a registered read port.
// Ports:
//   clk, rst        clock, synchronous active-low reset (output register only)
//   re_i            read request, captures mem[addr_i] into rdata_o
//   we_i, be_i      write request and per-byte enables
//   addr_i          line address
//   wdata_i         write line
//   rdata_o         registered read line; holds between reads
module data_mem_ram_core
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              re_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  be_t               be_i,
    input  line_t             wdata_i,
    output line_t             rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    line_t mem_q [DEPTH];
    line_t rdata_q;
    line_t wmerge;

    // Merge enabled bytes into the current line so the write is a whole-line store.
    always_comb begin
        wmerge = mem_q[addr_i];
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be_i[i]) begin
                wmerge[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wmerge;
        end
    end

    // Read samples the pre-write contents, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: processor line port plus a 32-bit streaming preloader.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   rden, wren, ip_address       processor read/write request and line address
//   byteena, writeData           per-byte enables and write line
//   readData, readValid          read line (held) and one-cycle valid pulse
//   mem_busy                     loader owns the RAM; processor requests dropped
//   ld_start, ld_base, ld_lines  start a load of ld_lines lines at ld_base
//   ld_valid, ld_ready, ld_data  loader word handshake
//   ld_done                      one-cycle pulse when the load completes
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rden,
    input  logic              wren,
    input  logic [ADDR_W-1:0] ip_address,
    input  be_t               byteena,
    input  line_t             writeData,
    output line_t             readData,
    output logic              readValid,
    output logic              mem_busy,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-1:0] ld_lines,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [LD_W-1:0]   ld_data,
    output logic              ld_done
);

    ld_state_t         state_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic [BEAT_W-1:0] beat_q;
    line_t             line_buf_q;
    logic              mem_busy_q;
    logic              ld_ready_q;
    logic              ld_done_q;

    logic              core_re;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    be_t               core_be;
    line_t             core_wdata;
    line_t             core_rdata;

    logic              rd_v0_q;
    line_t             last_data;
    logic              last_v;
    line_t             readdata_q;
    logic              readvalid_q;

    // Port mux: the loader's commit cycle takes the RAM; processor requests are gated while busy.
    always_comb begin
        core_re    = rden & ~mem_busy_q;
        core_we    = wren & ~mem_busy_q;
        core_addr  = ip_address;
        core_be    = byteena;
        core_wdata = writeData;
        if (state_q == LD_COMMIT) begin
            core_we    = 1'b1;
            core_addr  = ld_addr_q;
            core_be    = '1;
            core_wdata = line_buf_q;
        end
    end

    data_mem_ram_core u_ram (
        .clk     (clk),
        .rst     (rst),
        .re_i    (core_re),
        .we_i    (core_we),
        .addr_i  (core_addr),
        .be_i    (core_be),
        .wdata_i (core_wdata),
        .rdata_o (core_rdata)
    );

    // Valid tracking for the RAM's own output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_v0_q <= 1'b0;
        end else begin
            rd_v0_q <= core_re;
        end
    end

    // Optional extra pipeline stage for READ_LATENCY == 2.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            line_t mid_q;
            logic  mid_v_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    mid_q   <= '0;
                    mid_v_q <= 1'b0;
                end else begin
                    mid_v_q <= rd_v0_q;
                    if (rd_v0_q) begin
                        mid_q <= core_rdata;
                    end
                end
            end
            assign last_data = mid_q;
            assign last_v    = mid_v_q;
        end else begin : g_lat1
            assign last_data = core_rdata;
            assign last_v    = rd_v0_q;
        end
    endgenerate

    // Output register: readData only moves when a read returns.
    always_ff @(posedge clk) begin
        if (!rst) begin
            readdata_q  <= '0;
            readvalid_q <= 1'b0;
        end else begin
            readvalid_q <= last_v;
            if (last_v) begin
                readdata_q <= last_data;
            end
        end
    end

    // Loader FSM; outputs are registered alongside the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LD_IDLE;
            ld_addr_q   <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            line_buf_q  <= '0;
            mem_busy_q  <= 1'b0;
            ld_ready_q  <= 1'b0;
            ld_done_q   <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            unique case (state_q)
                LD_IDLE: begin
                    if (ld_start) begin
                        ld_addr_q   <= ld_base;
                        remaining_q <= ld_lines;
                        beat_q      <= '0;
                        mem_busy_q  <= 1'b1;
                        if (ld_lines == '0) begin
                            state_q   <= LD_DONE;
                            ld_done_q <= 1'b1;
                        end else begin
                            state_q    <= LD_FILL;
                            ld_ready_q <= 1'b1;
                        end
                    end
                end
                LD_FILL: begin
                    if (ld_valid) begin
                        for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
                            if (beat_q == BEAT_W'(k)) begin
                                line_buf_q[k*LD_W +: LD_W] <= ld_data;
                            end
                        end
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) begin
                            state_q    <= LD_COMMIT;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                LD_COMMIT: begin
                    ld_addr_q   <= ld_addr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                    if (remaining_q == ADDR_W'(1)) begin
                        state_q   <= LD_DONE;
                        ld_done_q <= 1'b1;
                    end else begin
                        state_q    <= LD_FILL;
                        ld_ready_q <= 1'b1;
                    end
                end
                LD_DONE: begin
                    state_q    <= LD_IDLE;
                    mem_busy_q <= 1'b0;
                end
                default: begin
                    state_q <= LD_IDLE;
                end
            endcase
        end
    end

    assign readData  = readdata_q;
    assign readValid = readvalid_q;
    assign mem_busy  = mem_busy_q;
    assign ld_ready  = ld_ready_q;
    assign ld_done   = ld_done_q;

endmodule
